key_bcd_editor: RTL and testbench

KEY_BCD_EDITOR -- requirements
Module: key_bcd_editor

---
 rtl/key_bcd_editor_pkg.sv | 18 +
 rtl/key_bcd_editor_if.sv | 26 ++
 rtl/key_bcd_editor_bcd_digit_step.sv | 21 ++
 rtl/key_bcd_editor.sv | 155 +++++++++++++++
 tb/tb_key_bcd_editor.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/key_bcd_editor_pkg.sv
// Shared types and constants for the 4-digit BCD key editor.
package key_bcd_editor_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned VALUE_W  = DIGIT_W * N_DIGITS;
  localparam int unsigned CURSOR_W = 2;
  localparam int unsigned TICK_W   = 16;
  localparam int unsigned CNT_W    = 32;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_e;

endpackage

// File: rtl/key_bcd_editor_if.sv
// Key pulses in, committed/working value and display hints out.
interface key_bcd_editor_if;
  import key_bcd_editor_pkg::*;

  logic                key_sel;
  logic                key_inc;
  logic                key_dec;
  logic                key_ok;
  logic [VALUE_W-1:0]  value_out;
  logic                value_upd;
  logic [VALUE_W-1:0]  edit_val;
  logic [CURSOR_W-1:0] cursor;
  logic                editing;
  logic                blink;

  modport master (
    output key_sel, key_inc, key_dec, key_ok,
    input  value_out, value_upd, edit_val, cursor, editing, blink
  );

  modport slave (
    input  key_sel, key_inc, key_dec, key_ok,
    output value_out, value_upd, edit_val, cursor, editing, blink
  );

endinterface

// File: rtl/key_bcd_editor_bcd_digit_step.sv
// Single BCD digit +1/-1 with wrap; simultaneous inc and dec cancel out.
module bcd_digit_step
  import key_bcd_editor_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (inc_i && !dec_i) begin
      digit_o = (digit_i >= BCD_MAX) ? 4'd0 : digit_i + 4'd1;
    end else if (dec_i && !inc_i) begin
      // Out-of-range codes fold to 9 so the digit always lands back in BCD.
      digit_o = (digit_i == 4'd0 || digit_i > BCD_MAX) ? BCD_MAX : digit_i - 4'd1;
    end
  end

endmodule

// File: rtl/key_bcd_editor.sv
// Four-digit BCD value editor: select/inc/dec/ok keys, ms timeout and cursor blink.
module key_bcd_editor
  import key_bcd_editor_pkg::*;
#(
  parameter int unsigned sclk_freq    = 50_000_000,
  parameter int unsigned edit_timeout = 5000,
  parameter int unsigned blink_period = 250
) (
  input  logic            sclk,
  input  logic            nrst,
  key_bcd_editor_if.slave bus
);

  localparam int unsigned TICK_DIV = (sclk_freq / 1000 > 0) ? sclk_freq / 1000 : 1;
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  TOUT_MAX  = CNT_W'(edit_timeout - 1);
  localparam logic [CNT_W-1:0]  BLINK_MAX = CNT_W'(blink_period - 1);

  state_e              state_q, state_d;
  logic [VALUE_W-1:0]  value_q, value_d;
  logic [VALUE_W-1:0]  edit_q, edit_d;
  logic [CURSOR_W-1:0] cursor_q, cursor_d;
  logic                upd_q, upd_d;
  logic                editing_q, editing_d;
  logic                blink_q, blink_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]    tout_cnt_q, tout_cnt_d;
  logic [CNT_W-1:0]    blink_cnt_q, blink_cnt_d;

  logic                tick_c;
  logic                any_key_c;
  logic [DIGIT_W-1:0]  sel_digit_c;
  logic [DIGIT_W-1:0]  step_digit_c;

  assign tick_c      = (tick_cnt_q == TICK_MAX);
  assign any_key_c   = bus.key_sel | bus.key_inc | bus.key_dec | bus.key_ok;
  assign sel_digit_c = edit_q[{cursor_q, 2'b00} +: DIGIT_W];

  bcd_digit_step u_step (
    .digit_i (sel_digit_c),
    .inc_i   (bus.key_inc),
    .dec_i   (bus.key_dec),
    .digit_o (step_digit_c)
  );

  // Free-running 1 ms prescaler.
  always_comb begin
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    edit_d      = edit_q;
    cursor_d    = cursor_q;
    upd_d       = 1'b0;
    blink_d     = blink_q;
    tout_cnt_d  = tout_cnt_q;
    blink_cnt_d = blink_cnt_q;

    unique case (state_q)
      IDLE: begin
        edit_d      = value_q;
        cursor_d    = '0;
        blink_d     = 1'b0;
        tout_cnt_d  = '0;
        blink_cnt_d = '0;
        if (bus.key_sel) begin
          state_d = EDIT;
          blink_d = 1'b1;
        end
      end

      EDIT: begin
        if (any_key_c) begin
          tout_cnt_d = '0;
        end else if (tick_c) begin
          tout_cnt_d = tout_cnt_q + CNT_W'(1);
        end

        if (tick_c) begin
          if (blink_cnt_q >= BLINK_MAX) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
          end
        end

        // Priority: ok, then sel, then inc/dec, then idle timeout.
        if (bus.key_ok) begin
          state_d     = IDLE;
          value_d     = edit_q;
          upd_d       = 1'b1;
          cursor_d    = '0;
          blink_d     = 1'b0;
          tout_cnt_d  = '0;
          blink_cnt_d = '0;
        end else if (bus.key_sel) begin
          cursor_d    = cursor_q + CURSOR_W'(1);
          blink_d     = 1'b1;
          blink_cnt_d = '0;
        end else if (bus.key_inc || bus.key_dec) begin
          edit_d[{cursor_q, 2'b00} +: DIGIT_W] = step_digit_c;
        end else if (tick_c && tout_cnt_q >= TOUT_MAX) begin
          state_d     = IDLE;
          edit_d      = value_q;
          cursor_d    = '0;
          blink_d     = 1'b0;
          tout_cnt_d  = '0;
          blink_cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    editing_d = (state_d == EDIT);
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      value_q     <= '0;
      edit_q      <= '0;
      cursor_q    <= '0;
      upd_q       <= 1'b0;
      editing_q   <= 1'b0;
      blink_q     <= 1'b0;
      tick_cnt_q  <= '0;
      tout_cnt_q  <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      edit_q      <= edit_d;
      cursor_q    <= cursor_d;
      upd_q       <= upd_d;
      editing_q   <= editing_d;
      blink_q     <= blink_d;
      tick_cnt_q  <= tick_cnt_d;
      tout_cnt_q  <= tout_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign bus.value_out = value_q;
  assign bus.value_upd = upd_q;
  assign bus.edit_val  = edit_q;
  assign bus.cursor    = cursor_q;
  assign bus.editing   = editing_q;
  assign bus.blink     = blink_q;

endmodule

// File: tb/tb_key_bcd_editor.sv
// Directed bench for key_bcd_editor: 1 kHz clock so one ms tick per cycle.
module tb_key_bcd_editor;

  logic sclk;
  logic nrst;
  int   n_checks;
  int   n_fail;
  int   upd_seen;
  int   upd_snap;

  key_bcd_editor_if bus ();

  key_bcd_editor #(
    .sclk_freq    (1000),
    .edit_timeout (10),
    .blink_period (3)
  ) dut (
    .sclk (sclk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    if (bus.value_upd) upd_seen++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timed out waiting for bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle key pulse; returns at the negedge after the capturing posedge.
  task automatic press(input logic sel, input logic inc, input logic dec, input logic ok);
    @(negedge sclk);
    bus.key_sel = sel;
    bus.key_inc = inc;
    bus.key_dec = dec;
    bus.key_ok  = ok;
    @(negedge sclk);
    bus.key_sel = 1'b0;
    bus.key_inc = 1'b0;
    bus.key_dec = 1'b0;
    bus.key_ok  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " value_out"}, bus.value_out, 16'h0000);
    chk({tag, " edit_val"},  bus.edit_val,  16'h0000);
    chk({tag, " cursor"},    16'(bus.cursor),    16'h0);
    chk({tag, " editing"},   16'(bus.editing),   16'h0);
    chk({tag, " blink"},     16'(bus.blink),     16'h0);
    chk({tag, " value_upd"}, 16'(bus.value_upd), 16'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    upd_seen = 0;
    bus.key_sel = 1'b0;
    bus.key_inc = 1'b0;
    bus.key_dec = 1'b0;
    bus.key_ok  = 1'b0;
    nrst = 1'b0;
    repeat (3) @(negedge sclk);
    check_all_zero("reset");
    nrst = 1'b1;
    @(negedge sclk);

    // Enter, +3, commit.
    press(1, 0, 0, 0);
    chk("enter editing", 16'(bus.editing), 16'h1);
    chk("enter blink",   16'(bus.blink),   16'h1);
    chk("enter cursor",  16'(bus.cursor),  16'h0);
    repeat (3) press(0, 1, 0, 0);
    chk("inc3 edit_val", bus.edit_val, 16'h0003);
    chk("inc3 value_out held", bus.value_out, 16'h0000);
    press(0, 0, 0, 1);
    chk("commit value_out", bus.value_out, 16'h0003);
    chk("commit upd high",  16'(bus.value_upd), 16'h1);
    chk("commit editing",   16'(bus.editing),   16'h0);
    chk("commit blink",     16'(bus.blink),     16'h0);
    @(negedge sclk);
    chk("commit upd one cycle", 16'(bus.value_upd), 16'h0);

    // Keys other than sel are ignored in IDLE.
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    chk("idle inc ignored", bus.edit_val, 16'h0003);
    chk("idle stays idle",  16'(bus.editing), 16'h0);

    // Bring value_out to 9, then check wrap without carry.
    press(1, 0, 0, 0);
    repeat (6) press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    chk("value 9", bus.value_out, 16'h0009);
    press(1, 0, 0, 0);
    chk("reload edit_val", bus.edit_val, 16'h0009);
    press(0, 1, 0, 0);
    chk("inc wrap no carry", bus.edit_val, 16'h0000);
    press(0, 0, 1, 0);
    chk("dec wrap no borrow", bus.edit_val, 16'h0009);

    // Cursor advance sequence with blink restart.
    press(1, 0, 0, 0); chk("cursor 1", 16'(bus.cursor), 16'h1); chk("blink after sel 1", 16'(bus.blink), 16'h1);
    press(1, 0, 0, 0); chk("cursor 2", 16'(bus.cursor), 16'h2); chk("blink after sel 2", 16'(bus.blink), 16'h1);
    press(1, 0, 0, 0); chk("cursor 3", 16'(bus.cursor), 16'h3); chk("blink after sel 3", 16'(bus.blink), 16'h1);
    press(1, 0, 0, 0); chk("cursor 0", 16'(bus.cursor), 16'h0); chk("blink after sel 4", 16'(bus.blink), 16'h1);
    press(1, 0, 0, 0); chk("cursor 1b", 16'(bus.cursor), 16'h1); chk("blink after sel 5", 16'(bus.blink), 16'h1);
    repeat (2) @(negedge sclk);
    chk("blink holds 2 ms", 16'(bus.blink), 16'h1);
    @(negedge sclk);
    chk("blink toggles at 3 ms", 16'(bus.blink), 16'h0);

    // Tens digit edits, inc+dec cancel, ok beats inc.
    press(0, 1, 0, 0);
    chk("tens inc", bus.edit_val, 16'h0019);
    press(0, 1, 1, 0);
    chk("inc+dec ignored", bus.edit_val, 16'h0019);
    upd_snap = upd_seen;
    press(0, 1, 0, 1);
    chk("ok+inc commits pre-inc", bus.value_out, 16'h0019);
    chk("ok+inc upd", 16'(bus.value_upd), 16'h1);
    chk("ok+inc editing", 16'(bus.editing), 16'h0);

    // sel beats inc.
    press(1, 0, 0, 0);
    press(1, 1, 0, 0);
    chk("sel+inc cursor", 16'(bus.cursor), 16'h1);
    chk("sel+inc edit_val", bus.edit_val, 16'h0019);

    // Timeout: thousands +1 then idle for 10 ms.
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    chk("thousands inc", bus.edit_val, 16'h1019);
    upd_snap = upd_seen;
    repeat (9) @(negedge sclk);
    chk("pre-timeout editing", 16'(bus.editing), 16'h1);
    @(negedge sclk);
    chk("timeout editing", 16'(bus.editing), 16'h0);
    chk("timeout edit_val reload", bus.edit_val, 16'h0019);
    chk("timeout value_out", bus.value_out, 16'h0019);
    chk("timeout no upd", 16'(upd_seen - upd_snap), 16'h0);

    // Build 0x1234 then reset mid-edit.
    press(1, 0, 0, 0);
    repeat (5) press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    repeat (2) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    repeat (2) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    chk("build 1234", bus.edit_val, 16'h1234);
    #2;
    upd_snap = upd_seen;
    nrst = 1'b0;
    #1;
    check_all_zero("async reset");
    repeat (2) @(negedge sclk);
    nrst = 1'b1;
    repeat (3) @(negedge sclk);
    chk("post reset no upd", 16'(upd_seen - upd_snap), 16'h0);
    chk("post reset value_out", bus.value_out, 16'h0000);
    chk("post reset editing", 16'(bus.editing), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
